// File: rtl/cmp_result_monitor.sv
// Outcome monitor behind the 8-bit magnitude comparator: saturating per-flag counters, sticky one-hot error and an eq-lock FSM.
// Optional CMP_TREND_EN adds a 2-bit gt/lt trend output built from the last four legal non-eq samples.
module cmp_result_monitor #(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned LOCK_N = 4,
    parameter int unsigned LOSS_N = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             eq,
    input  logic             gt,
    input  logic             lt,
    input  logic             clear,
    output logic [CNT_W-1:0] cnt_eq,
    output logic [CNT_W-1:0] cnt_gt,
    output logic [CNT_W-1:0] cnt_lt,
    output logic             lock,
    output logic             lock_pulse,
    output logic             err_onehot
`ifdef CMP_TREND_EN
    ,
    output logic [1:0]       trend
`endif
);

    localparam logic [8:0] LOCK_C = 9'(LOCK_N);
    localparam logic [8:0] LOSS_C = 9'(LOSS_N);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t           r_state;
    logic [7:0]       r_run;
    logic [7:0]       r_miss;
    logic [CNT_W-1:0] r_cnt_eq;
    logic [CNT_W-1:0] r_cnt_gt;
    logic [CNT_W-1:0] r_cnt_lt;
    logic             r_lock;
    logic             r_lock_pulse;
    logic             r_err;

    logic             w_legal;
    logic [8:0]       w_run_inc;
    logic [8:0]       w_miss_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_legal    = (eq & ~gt & ~lt) | (~eq & gt & ~lt) | (~eq & ~gt & lt);
    assign w_run_inc  = {1'b0, r_run} + 9'd1;
    assign w_miss_inc = {1'b0, r_miss} + 9'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= SEARCH;
            r_run        <= '0;
            r_miss       <= '0;
            r_cnt_eq     <= '0;
            r_cnt_gt     <= '0;
            r_cnt_lt     <= '0;
            r_lock       <= 1'b0;
            r_lock_pulse <= 1'b0;
            r_err        <= 1'b0;
        end else if (clear) begin
            // clear wins over any same-cycle sample, which is dropped
            r_state      <= SEARCH;
            r_run        <= '0;
            r_miss       <= '0;
            r_cnt_eq     <= '0;
            r_cnt_gt     <= '0;
            r_cnt_lt     <= '0;
            r_lock       <= 1'b0;
            r_lock_pulse <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_lock_pulse <= 1'b0;
            if (in_valid && !w_legal) begin
                r_err   <= 1'b1;
                r_state <= SEARCH;
                r_lock  <= 1'b0;
                r_run   <= '0;
                r_miss  <= '0;
            end else if (in_valid) begin
                if (eq) r_cnt_eq <= sat_inc(r_cnt_eq);
                if (gt) r_cnt_gt <= sat_inc(r_cnt_gt);
                if (lt) r_cnt_lt <= sat_inc(r_cnt_lt);
                case (r_state)
                    SEARCH: begin
                        if (eq) begin
                            if (w_run_inc == LOCK_C) begin
                                r_state      <= LOCKED;
                                r_lock       <= 1'b1;
                                r_lock_pulse <= 1'b1;
                                r_run        <= '0;
                                r_miss       <= '0;
                            end else begin
                                r_run <= w_run_inc[7:0];
                            end
                        end else begin
                            r_run <= '0;
                        end
                    end
                    LOCKED: begin
                        if (eq) begin
                            r_miss <= '0;
                        end else if (w_miss_inc == LOSS_C) begin
                            r_state <= SEARCH;
                            r_lock  <= 1'b0;
                            r_miss  <= '0;
                        end else begin
                            r_miss <= w_miss_inc[7:0];
                        end
                    end
                    default: begin
                        r_state <= SEARCH;
                        r_lock  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cnt_eq     = r_cnt_eq;
    assign cnt_gt     = r_cnt_gt;
    assign cnt_lt     = r_cnt_lt;
    assign lock       = r_lock;
    assign lock_pulse = r_lock_pulse;
    assign err_onehot = r_err;

`ifdef CMP_TREND_EN
    // History is a run length of identical non-eq outcomes, capped at 4
    logic       r_dir_gt;
    logic [2:0] r_same;
    logic [1:0] r_trend;
    logic [2:0] w_same_nxt;

    always_comb begin
        w_same_nxt = 3'd1;
        if (r_same != 3'd0 && r_dir_gt == gt)
            w_same_nxt = (r_same == 3'd4) ? 3'd4 : r_same + 3'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dir_gt <= 1'b0;
            r_same   <= '0;
            r_trend  <= 2'b00;
        end else if (clear || (in_valid && !w_legal)) begin
            r_dir_gt <= 1'b0;
            r_same   <= '0;
            r_trend  <= 2'b00;
        end else if (in_valid && !eq) begin
            r_dir_gt <= gt;
            r_same   <= w_same_nxt;
            r_trend  <= (w_same_nxt == 3'd4) ? (gt ? 2'b01 : 2'b10) : 2'b00;
        end
    end

    assign trend = r_trend;
`endif

endmodule

// File: tb/tb_cmp_result_monitor.sv
// Scoreboard bench for cmp_result_monitor: directed vectors push hand-computed expectations, a monitor pops one per clock.
module tb_cmp_result_monitor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, eq = 1'b0, gt = 1'b0, lt = 1'b0, clear = 1'b0;
    logic [15:0] cnt_eq, cnt_gt, cnt_lt;
    logic        lock, lock_pulse, err_onehot;
    logic [3:0]  c4_eq, c4_gt, c4_lt;
    logic        l4, p4, e4;
`ifdef CMP_TREND_EN
    logic [1:0]  trend, trend4;
`endif

    always #5 clk = ~clk;

    cmp_result_monitor #(.CNT_W(16), .LOCK_N(4), .LOSS_N(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .eq(eq), .gt(gt), .lt(lt), .clear(clear),
        .cnt_eq(cnt_eq), .cnt_gt(cnt_gt), .cnt_lt(cnt_lt),
        .lock(lock), .lock_pulse(lock_pulse), .err_onehot(err_onehot)
`ifdef CMP_TREND_EN
        , .trend(trend)
`endif
    );

    cmp_result_monitor #(.CNT_W(4), .LOCK_N(4), .LOSS_N(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .eq(eq), .gt(gt), .lt(lt), .clear(clear),
        .cnt_eq(c4_eq), .cnt_gt(c4_gt), .cnt_lt(c4_lt),
        .lock(l4), .lock_pulse(p4), .err_onehot(e4)
`ifdef CMP_TREND_EN
        , .trend(trend4)
`endif
    );

    typedef struct {
        string       nm;
        logic [15:0] ce, cg, cl;
        logic        lk, lp, er;
        logic        c4;
        logic [3:0]  c4g;
        logic        ct;
        logic [1:0]  tr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic       chk4 = 1'b0;
    logic [3:0] x4g  = '0;
    logic       chkt = 1'b0;
    logic [1:0] xtr  = 2'b00;

    task automatic drive(input string nm, input logic v, input logic e, input logic g,
                         input logic l, input logic c, input int xe, input int xg,
                         input int xl, input logic xlk, input logic xp, input logic xer);
        exp_t x;
        @(posedge clk);
        #2;
        in_valid = v; eq = e; gt = g; lt = l; clear = c;
        x.nm = nm; x.ce = 16'(xe); x.cg = 16'(xg); x.cl = 16'(xl);
        x.lk = xlk; x.lp = xp; x.er = xer;
        x.c4 = chk4; x.c4g = x4g; x.ct = chkt; x.tr = xtr;
        exp_q.push_back(x);
    endtask

    task automatic check_zero(input string nm);
        n_checks++;
        if ({cnt_eq, cnt_gt, cnt_lt, lock, lock_pulse, err_onehot} == '0) n_pass++;
        else $display("FAIL %s: got eq=%0d gt=%0d lt=%0d lock=%b pulse=%b err=%b, need all 0",
                      nm, cnt_eq, cnt_gt, cnt_lt, lock, lock_pulse, err_onehot);
    endtask

    // Monitor: outputs become valid 1 ns after each rising edge
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                n_checks++;
                if (cnt_eq == x.ce && cnt_gt == x.cg && cnt_lt == x.cl &&
                    lock == x.lk && lock_pulse == x.lp && err_onehot == x.er)
                    n_pass++;
                else
                    $display("FAIL %s: got eq=%0d gt=%0d lt=%0d lock=%b pulse=%b err=%b, need eq=%0d gt=%0d lt=%0d lock=%b pulse=%b err=%b",
                             x.nm, cnt_eq, cnt_gt, cnt_lt, lock, lock_pulse, err_onehot,
                             x.ce, x.cg, x.cl, x.lk, x.lp, x.er);
                if (x.c4) begin
                    n_checks++;
                    if (c4_gt == x.c4g && c4_eq == 4'd0 && c4_lt == 4'd0) n_pass++;
                    else $display("FAIL %s/w4: got eq=%0d gt=%0d lt=%0d, need eq=0 gt=%0d lt=0",
                                  x.nm, c4_eq, c4_gt, c4_lt, x.c4g);
                end
`ifdef CMP_TREND_EN
                if (x.ct) begin
                    n_checks++;
                    if (trend == x.tr) n_pass++;
                    else $display("FAIL %s/trend: got %b, need %b", x.nm, trend, x.tr);
                end
`endif
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        #1;
        rst_n = 1'b1;

        // Reset and count
        drive("t1_gt1", 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        drive("t1_gt2", 1, 0, 1, 0, 0, 0, 2, 0, 0, 0, 0);
        drive("t1_gt3", 1, 0, 1, 0, 0, 0, 3, 0, 0, 0, 0);
        drive("t1_lt1", 1, 0, 0, 1, 0, 0, 3, 1, 0, 0, 0);
        drive("t1_lt2", 1, 0, 0, 1, 0, 0, 3, 2, 0, 0, 0);
        drive("t1_eq1", 1, 1, 0, 0, 0, 1, 3, 2, 0, 0, 0);
        drive("t1_eq2", 1, 1, 0, 0, 0, 2, 3, 2, 0, 0, 0);
        drive("t1_eq3", 1, 1, 0, 0, 0, 3, 3, 2, 0, 0, 0);
        drive("t1_eq4", 1, 1, 0, 0, 0, 4, 3, 2, 1, 1, 0);
        drive("t1_eq5", 1, 1, 0, 0, 0, 5, 3, 2, 1, 0, 0);
        drive("t1_clr", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

        // Holes do not break a run; an eq between misses resets the miss count
        drive("t2_eq1", 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        drive("t2_hole1", 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        drive("t2_eq2", 1, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0);
        drive("t2_hole2", 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0);
        drive("t2_eq3", 1, 1, 0, 0, 0, 3, 0, 0, 0, 0, 0);
        drive("t2_eq4", 1, 1, 0, 0, 0, 4, 0, 0, 1, 1, 0);
        drive("t2_gt1", 1, 0, 1, 0, 0, 4, 1, 0, 1, 0, 0);
        drive("t2_eq5", 1, 1, 0, 0, 0, 5, 1, 0, 1, 0, 0);
        drive("t2_gt2", 1, 0, 1, 0, 0, 5, 2, 0, 1, 0, 0);
        drive("t2_gt3", 1, 0, 1, 0, 0, 5, 3, 0, 0, 0, 0);

        // One-hot error while locked, then illegal 000 breaking a run
        drive("t3_eq6", 1, 1, 0, 0, 0, 6, 3, 0, 0, 0, 0);
        drive("t3_eq7", 1, 1, 0, 0, 0, 7, 3, 0, 0, 0, 0);
        drive("t3_eq8", 1, 1, 0, 0, 0, 8, 3, 0, 0, 0, 0);
        drive("t3_eq9", 1, 1, 0, 0, 0, 9, 3, 0, 1, 1, 0);
        drive("t3_ill110", 1, 1, 1, 0, 0, 9, 3, 0, 0, 0, 1);
        drive("t3_hole", 0, 0, 0, 0, 0, 9, 3, 0, 0, 0, 1);
        drive("t3_eq10", 1, 1, 0, 0, 0, 10, 3, 0, 0, 0, 1);
        drive("t3_ill000", 1, 0, 0, 0, 0, 10, 3, 0, 0, 0, 1);
        drive("t3_ill111", 1, 1, 1, 1, 0, 10, 3, 0, 0, 0, 1);
        drive("t3_eq11", 1, 1, 0, 0, 0, 11, 3, 0, 0, 0, 1);
        drive("t3_eq12", 1, 1, 0, 0, 0, 12, 3, 0, 0, 0, 1);
        drive("t3_eq13", 1, 1, 0, 0, 0, 13, 3, 0, 0, 0, 1);
        drive("t3_eq14", 1, 1, 0, 0, 0, 14, 3, 0, 1, 1, 1);

        // Clear wins over a same-cycle eq sample
        drive("t4_clr_eq", 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        drive("t4_eq1", 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        drive("t4_eq2", 1, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0);
        drive("t4_eq3", 1, 1, 0, 0, 0, 3, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-run
        @(posedge clk);
        #2;
        in_valid = 1'b0; eq = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive("t5_eq1", 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        drive("t5_eq2", 1, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0);
        drive("t5_eq3", 1, 1, 0, 0, 0, 3, 0, 0, 0, 0, 0);
        drive("t5_eq4", 1, 1, 0, 0, 0, 4, 0, 0, 1, 1, 0);
        drive("t5_eq5", 0, 0, 0, 0, 0, 4, 0, 0, 1, 0, 0);

        // Saturation: 20 gt on a 4-bit-counter instance alongside the 16-bit one
        chk4 = 1'b1; x4g = 4'd0;
        drive("t6_clr", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            x4g = (i > 15) ? 4'd15 : 4'(i);
            drive($sformatf("t6_gt%0d", i), 1, 0, 1, 0, 0, 0, i, 0, 0, 0, 0);
        end
        chk4 = 1'b0;

        // Trend history
`ifdef CMP_TREND_EN
        chkt = 1'b1;
`endif
        xtr = 2'b00;
        drive("t7_clr", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        drive("t7_gt1", 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        drive("t7_gt2", 1, 0, 1, 0, 0, 0, 2, 0, 0, 0, 0);
        drive("t7_gt3", 1, 0, 1, 0, 0, 0, 3, 0, 0, 0, 0);
        xtr = 2'b01;
        drive("t7_gt4", 1, 0, 1, 0, 0, 0, 4, 0, 0, 0, 0);
        drive("t7_eq", 1, 1, 0, 0, 0, 1, 4, 0, 0, 0, 0);
        drive("t7_hole", 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0);
        xtr = 2'b00;
        drive("t7_lt1", 1, 0, 0, 1, 0, 1, 4, 1, 0, 0, 0);
        drive("t7_lt2", 1, 0, 0, 1, 0, 1, 4, 2, 0, 0, 0);
        drive("t7_lt3", 1, 0, 0, 1, 0, 1, 4, 3, 0, 0, 0);
        xtr = 2'b10;
        drive("t7_lt4", 1, 0, 0, 1, 0, 1, 4, 4, 0, 0, 0);
        xtr = 2'b00;
        drive("t7_clr2", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        chkt = 1'b0;

        @(posedge clk);
        #2;
        in_valid = 1'b0; clear = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, need 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cmp_result_monitor.md
Name:
cmp_result_monitor

Overview:
- Stage directly downstream of the 8-bit magnitude comparator; consumes its eq/gt/lt flags one sample per clock qualified by in_valid.
- Keeps saturating occurrence counters per outcome and checks that the flags are one-hot.
- Runs a lock FSM: asserts lock after a run of consecutive equal samples and drops it after a run of consecutive misses.
- Output feeds status and interrupt logic.

Parameters:
- CNT_W, 16: width of each occurrence counter.
- LOCK_N, 4: consecutive eq samples required to enter LOCKED. Legal range 1..255.
- LOSS_N, 2: consecutive non-eq samples required to leave LOCKED. Legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  eq/gt/lt carry a sample this cycle.
- eq  input  1  comparator equal flag.
- gt  input  1  comparator greater-than flag.
- lt  input  1  comparator less-than flag.
- clear  input  1  synchronous clear of counters, error and FSM.
- cnt_eq  output  CNT_W  count of accepted eq samples.
- cnt_gt  output  CNT_W  count of accepted gt samples.
- cnt_lt  output  CNT_W  count of accepted lt samples.
- lock  output  1  high while the FSM is in LOCKED.
- lock_pulse  output  1  one-cycle pulse on entry to LOCKED.
- err_onehot  output  1  sticky flag: a non-one-hot sample was seen.

Behaviour:
- Reset: one clock domain, clk. rst_n is asynchronous and active-low. While rst_n=0, all outputs are 0, the FSM is in SEARCH, and the run and miss counters are 0.
- A sample is accepted on a rising clk edge with in_valid=1 and clear=0. All outputs are registered, so every effect appears one cycle after acceptance.
- One-hot check: a sample is legal only when exactly one of eq/gt/lt is 1.
- Illegal sample (000, 011, 101, 110 or 111):
  - sets err_onehot;
  - does not change any counter;
  - forces the FSM to SEARCH with run=0 and miss=0;
  - deasserts lock on the next cycle;
  - does not pulse lock_pulse.
- Counters: a legal sample increments the matching counter by 1. Counters saturate at all-ones and never wrap.
- in_valid=0 cycles are holes. They change nothing and do not break a run.
- clear=1 takes priority over a same-cycle sample, which is dropped. It zeroes all counters, err_onehot, run and miss, and puts the FSM in SEARCH. lock goes to 0 the next cycle.
- FSM state SEARCH (lock=0):
  - legal eq: run increments (run is 8 bits wide). When run+1 == LOCK_N, go to LOCKED, set run=0, miss=0, and pulse lock_pulse for exactly one cycle, coincident with lock first reading 1.
  - legal gt or lt: run=0.
- FSM state LOCKED (lock=1):
  - legal eq: miss=0.
  - legal gt or lt: miss increments. When miss+1 == LOSS_N, go to SEARCH and set miss=0.
- LOCK_N=1: the first eq locks on the next cycle. LOSS_N=1: the first miss unlocks.
- rst_n asserted mid-run: all state clears immediately and asynchronously, with no pulse.

Optional Feature:
- Macro: CMP_TREND_EN.
- Defined: adds output trend [1:0], reset value 00, registered with the same one-cycle latency.
  - trend=01 after the last 4 legal non-eq samples were all gt.
  - trend=10 after the last 4 legal non-eq samples were all lt.
  - Otherwise trend=00.
  - eq samples and holes are ignored by the trend history.
  - Illegal samples, clear and reset empty the history, forcing trend=00.
- Undefined: the trend port and its logic do not exist; all other behaviour is identical.

Test Plan:
- Reset and count: rst_n=0 then release, followed by 3 gt, 2 lt and 5 eq samples with LOCK_N=4 → cnt_gt=3, cnt_lt=2, cnt_eq=5; lock=1 one cycle after the 4th eq; lock_pulse high for exactly that cycle.
- Holes and unlock: eq, idle, eq, idle, eq, eq → lock rises after the 4th eq; then gt, eq, gt → still locked (miss reset by eq); then gt, gt → lock=0 one cycle after the second consecutive gt.
- One-hot error: while locked, feed eq=1/gt=1/lt=0 → err_onehot=1, lock=0 next cycle, all counters unchanged; err_onehot stays 1 until clear.
- Saturation: with CNT_W=4, feed 20 gt samples → cnt_gt=15 and stays 15; cnt_eq and cnt_lt stay 0.
- Clear priority and reset mid-run: assert clear with in_valid=1 and eq=1 → counters 0, FSM in SEARCH, sample dropped; separately, pull rst_n low after 3 eq → outputs go 0 immediately, and 4 further eq are needed to lock.
- CMP_TREND_EN: feed gt×4 → trend=01; then lt → trend=00; then lt×3 more → trend=10; then clear → trend=00.
